// File: rtl/conv_pkg.sv
// Shared fixed-point helpers for the conv layer 19 MAC datapath.
package conv_pkg;
  localparam int KERNEL_SIZE = 9;
  localparam int DATA_W      = 32;
  localparam int FRAC_BITS   = 16;
  localparam int ACC_WIDTH   = DATA_W + 8;

  // Full-precision product, floor-shifted back to Q.FRAC_BITS, truncated to ACC_WIDTH.
  function automatic logic signed [ACC_WIDTH-1:0] fx_mul(input logic signed [DATA_W-1:0] a,
                                                          input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    p = p >>> FRAC_BITS;
    return p[ACC_WIDTH-1:0];
  endfunction

  // In range iff every bit above the result sign bit matches it.
  function automatic logic [DATA_W-1:0] sat_to_data(input logic signed [ACC_WIDTH-1:0] acc);
    if ((&acc[ACC_WIDTH-1:DATA_W-1]) || !(|acc[ACC_WIDTH-1:DATA_W-1]))
      return acc[DATA_W-1:0];
    else if (acc[ACC_WIDTH-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction
endpackage

// File: rtl/conv_3x3_row_mac.sv
// One kernel row: three fixed-point multipliers (S1) and the row adder (S2).
module conv_3x3_row_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en_s1,
  input  logic                            en_s2,
  input  logic [2:0][DATA_WIDTH-1:0]      pixel,
  input  logic [2:0][DATA_WIDTH-1:0]      weight,
  output logic [ACC_WIDTH-1:0]            row_sum
);
  import conv_pkg::*;

  logic [2:0][ACC_WIDTH-1:0] prod_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q  <= '0;
      row_sum <= '0;
    end else begin
      if (en_s1)
        for (int t = 0; t < 3; t++) prod_q[t] <= fx_mul(pixel[t], weight[t]);
      if (en_s2)
        row_sum <= prod_q[0] + prod_q[1] + prod_q[2];
    end
  end
endmodule

// File: rtl/conv_3x3_mac_accum_19.sv
// 3x3 window MAC with per-channel accumulation and saturated output, 4-cycle latency.
module conv_3x3_mac_accum_19 #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16,
  parameter int IN_CHANNELS = 4,
  parameter int CNT_WIDTH   = 2,
  parameter int ACC_WIDTH   = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  weight_load,
  input  logic [DATA_WIDTH-1:0] weight_in_00,
  input  logic [DATA_WIDTH-1:0] weight_in_01,
  input  logic [DATA_WIDTH-1:0] weight_in_02,
  input  logic [DATA_WIDTH-1:0] weight_in_03,
  input  logic [DATA_WIDTH-1:0] weight_in_04,
  input  logic [DATA_WIDTH-1:0] weight_in_05,
  input  logic [DATA_WIDTH-1:0] weight_in_06,
  input  logic [DATA_WIDTH-1:0] weight_in_07,
  input  logic [DATA_WIDTH-1:0] weight_in_08,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pixel_in_00,
  input  logic [DATA_WIDTH-1:0] pixel_in_01,
  input  logic [DATA_WIDTH-1:0] pixel_in_02,
  input  logic [DATA_WIDTH-1:0] pixel_in_03,
  input  logic [DATA_WIDTH-1:0] pixel_in_04,
  input  logic [DATA_WIDTH-1:0] pixel_in_05,
  input  logic [DATA_WIDTH-1:0] pixel_in_06,
  input  logic [DATA_WIDTH-1:0] pixel_in_07,
  input  logic [DATA_WIDTH-1:0] pixel_in_08,
  output logic                  weights_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  valid_out
);
  import conv_pkg::*;

  localparam int STAGES = 3;
  localparam logic [CNT_WIDTH-1:0] LAST_CH = CNT_WIDTH'(IN_CHANNELS - 1);

  // The arithmetic helpers are sized by the package; refuse a mismatched build.
  if (FRAC_BITS != conv_pkg::FRAC_BITS || DATA_WIDTH != DATA_W ||
      ACC_WIDTH != conv_pkg::ACC_WIDTH || IN_CHANNELS < 1 || CNT_WIDTH < 1) begin : g_cfg_err
    $error("conv_3x3_mac_accum_19: parameters do not match conv_pkg");
  end

  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] wt_q, px;
  logic [2:0][ACC_WIDTH-1:0]              row_sum;
  logic [STAGES:1]                        vld_pipe;
  logic                                   accept;
  logic [ACC_WIDTH-1:0]                   win_sum, acc, acc_next;
  logic [CNT_WIDTH-1:0]                   cnt;

  assign px = {pixel_in_08, pixel_in_07, pixel_in_06, pixel_in_05, pixel_in_04,
               pixel_in_03, pixel_in_02, pixel_in_01, pixel_in_00};
  assign accept = valid_in && weights_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wt_q          <= '0;
      weights_ready <= 1'b0;
    end else if (weight_load) begin
      wt_q <= {weight_in_08, weight_in_07, weight_in_06, weight_in_05, weight_in_04,
               weight_in_03, weight_in_02, weight_in_01, weight_in_00};
      weights_ready <= 1'b1;
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    conv_3x3_row_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_row (
      .clk     (clk),
      .reset   (reset),
      .en_s1   (accept),
      .en_s2   (vld_pipe[1]),
      .pixel   (px[3*r+2 -: 3]),
      .weight  (wt_q[3*r+2 -: 3]),
      .row_sum (row_sum[r])
    );
  end

  assign acc_next = (cnt == '0) ? win_sum : acc + win_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe  <= '0;
      win_sum   <= '0;
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      valid_out <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
      valid_out <= 1'b0;
      if (vld_pipe[2])
        win_sum <= row_sum[0] + row_sum[1] + row_sum[2];
      if (vld_pipe[3]) begin
        acc <= acc_next;
        if (cnt == LAST_CH) begin
          out       <= sat_to_data(acc_next);
          valid_out <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_3x3_mac_accum_19.sv
// Directed + random bench for conv_3x3_mac_accum_19 against a plain-arithmetic model.
module tb_conv_3x3_mac_accum_19;
  localparam int IN_CH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        weight_load = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] wts [9];
  logic [31:0] pix [9];
  logic        weights_ready, valid_out;
  logic [31:0] dout;

  int checks = 0, errors = 0;
  int ncyc = 0, n_vout = 0;
  logic [31:0] last_vout_val = '0;

  // model state
  typedef struct { int due; logic [31:0] val; } exp_t;
  exp_t        q[$];
  logic [31:0] m_w [9];
  logic        m_ready = 1'b0;
  longint      m_acc = 0;
  int          m_cnt = 0;
  logic [31:0] m_out = '0;

  always #5 clk = ~clk;

  conv_3x3_mac_accum_19 dut (
    .clk(clk), .reset(reset), .weight_load(weight_load),
    .weight_in_00(wts[0]), .weight_in_01(wts[1]), .weight_in_02(wts[2]),
    .weight_in_03(wts[3]), .weight_in_04(wts[4]), .weight_in_05(wts[5]),
    .weight_in_06(wts[6]), .weight_in_07(wts[7]), .weight_in_08(wts[8]),
    .valid_in(valid_in),
    .pixel_in_00(pix[0]), .pixel_in_01(pix[1]), .pixel_in_02(pix[2]),
    .pixel_in_03(pix[3]), .pixel_in_04(pix[4]), .pixel_in_05(pix[5]),
    .pixel_in_06(pix[6]), .pixel_in_07(pix[7]), .pixel_in_08(pix[8]),
    .weights_ready(weights_ready), .out(dout), .valid_out(valid_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  function automatic longint w40(input longint x);
    return (x <<< 24) >>> 24;
  endfunction

  function automatic logic [31:0] sat32(input longint a);
    if (a > 64'sd2147483647) return 32'h7fff_ffff;
    if (a < -64'sd2147483648) return 32'h8000_0000;
    return a[31:0];
  endfunction

  function automatic longint window_sum();
    longint s = 0;
    for (int i = 0; i < 9; i++)
      s += w40((longint'($signed(pix[i])) * longint'($signed(m_w[i]))) >>> 16);
    return w40(s);
  endfunction

  task automatic model_edge();
    if (!reset) begin
      q.delete(); m_ready = 1'b0; m_acc = 0; m_cnt = 0; m_out = '0;
      for (int i = 0; i < 9; i++) m_w[i] = '0;
    end else begin
      if (valid_in && m_ready) begin
        m_acc = (m_cnt == 0) ? window_sum() : w40(m_acc + window_sum());
        m_cnt++;
        if (m_cnt == IN_CH) begin
          q.push_back('{due: ncyc + 3, val: sat32(m_acc)});
          m_cnt = 0;
        end
      end
      if (weight_load) begin
        for (int i = 0; i < 9; i++) m_w[i] = wts[i];
        m_ready = 1'b1;
      end
    end
  endtask

  task automatic step();
    logic exp_v;
    @(posedge clk);
    ncyc++;
    model_edge();
    @(negedge clk);
    exp_v = (q.size() > 0) && (q[0].due == ncyc);
    chk("valid_out", valid_out, exp_v);
    if (exp_v) begin
      m_out = q[0].val;
      void'(q.pop_front());
    end else if (q.size() > 0 && q[0].due < ncyc) begin
      void'(q.pop_front());
    end
    chk("out", dout, m_out);
    chk("weights_ready", weights_ready, m_ready);
    if (valid_out) begin
      n_vout++;
      last_vout_val = dout;
    end
  endtask

  task automatic fill_px(input logic [31:0] v);
    for (int i = 0; i < 9; i++) pix[i] = v;
  endtask

  task automatic fill_wt(input logic [31:0] v);
    for (int i = 0; i < 9; i++) wts[i] = v;
  endtask

  task automatic load(input logic [31:0] v);
    fill_wt(v); weight_load = 1'b1; step(); weight_load = 1'b0;
  endtask

  task automatic send(input int n);
    valid_in = 1'b1;
    repeat (n) step();
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b0; step(); reset = 1'b1; step();
  endtask

  initial begin
    int v0;
    fill_wt('0); fill_px('0);
    for (int i = 0; i < 9; i++) m_w[i] = '0;
    step();
    chk("reset_out", dout, 32'h0);
    chk("reset_vout", valid_out, 1'b0);
    reset = 1'b1; step();

    // windows before any weight load are dropped
    fill_px(32'h0001_0000); v0 = n_vout;
    send(6); idle(6);
    chk("gate_nvout", n_vout - v0, 0);
    chk("gate_ready", weights_ready, 1'b0);

    // basic sum: 4 windows of 0.5 with unit weights -> 18.0
    load(32'h0001_0000); fill_px(32'h0000_8000); v0 = n_vout;
    send(4); idle(6);
    chk("basic_nvout", n_vout - v0, 1);
    chk("basic_val", last_vout_val, 32'h0012_0000);

    // mixed signs cancel per window
    fill_wt('0); wts[0] = 32'hFFFF_0000; wts[1] = 32'h0002_0000;
    weight_load = 1'b1; step(); weight_load = 1'b0;
    fill_px('0); pix[0] = 32'h0003_0000; pix[1] = 32'h0001_8000; v0 = n_vout;
    send(4); idle(6);
    chk("mixed_nvout", n_vout - v0, 1);
    chk("mixed_val", last_vout_val, 32'h0);

    // saturation both ways
    load(32'h7FFF_0000); fill_px(32'h0002_0000);
    send(4); idle(6);
    chk("sat_pos", last_vout_val, 32'h7FFF_FFFF);
    fill_px(32'hFFFE_0000);
    send(4); idle(6);
    chk("sat_neg", last_vout_val, 32'h8000_0000);

    // load in same cycle as a window: that window sees the old weights
    load(32'h0001_0000); fill_px(32'h0001_0000);
    fill_wt(32'h0002_0000); weight_load = 1'b1; valid_in = 1'b1; step(); weight_load = 1'b0;
    send(3); idle(6);
    chk("samecyc_val", last_vout_val, 32'h003F_0000);

    // reset mid-group discards the partial sum
    send(2);
    do_reset();
    chk("rst_ready", weights_ready, 1'b0);
    v0 = n_vout;
    load(32'h0001_0000); send(4); idle(6);
    chk("rst_nvout", n_vout - v0, 1);
    chk("rst_val", last_vout_val, 32'h0024_0000);

    // random traffic: bubbles, reloads, wide operands, rare resets
    for (int c = 0; c < 600; c++) begin
      valid_in = ($urandom_range(0, 9) < 7);
      weight_load = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 9; i++) begin
        wts[i] = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000);
        pix[i] = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000);
      end
      if ($urandom_range(0, 99) == 0) reset = 1'b0;
      step();
      reset = 1'b1;
    end
    valid_in = 1'b0; weight_load = 1'b0;
    idle(8);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
